fpu_mult_seq: RTL and testbench
===============================

Name: fpu_mult_seq

Overview:
- Parametrised, iterative IEEE 754 multiplier. It is the area-lean successor to the single-precision combinational multiplier.
- Adds the following over that multiplier:
  - configurable exponent and mantissa widths;
  - the five RISC-V rounding modes;
  - special-operand handling and exception flags;
  - valid/ready handshakes on both sides.
- Sits behind the FPU register interface.
- Computes one significand bit per cycle, trading latency for area.

Parameters:
- EXP_W, 8, exponent width. Derived: BIAS = 2^(EXP_W-1)-1.
- MAN_W, 23, stored fraction width. Derived: SIG_W = MAN_W+1 and W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operands and rm are valid
- in_ready  out  1  block can accept an operation
- a  in  W  operand A
- b  in  W  operand B
- rm  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 are treated as RNE
- out_valid  out  1  result and flags are valid
- out_ready  in  1  consumer accepts the result
- result  out  W  product
- flags  out  5  {NV, DZ, OF, UF, NX}; DZ is always 0

Behaviour:
- Reset:
  - state = IDLE, in_ready = 1, out_valid = 0, result = 0, flags = 0.
  - Asserting rst mid-operation abandons the operation. No output results from it.
- Handshakes:
  - in_ready = (state == IDLE).
  - An operation is accepted on a clk edge with in_valid && in_ready; a, b and rm are registered then.
  - out_valid holds with result and flags stable until out_valid && out_ready. The block returns to IDLE on the same edge.
  - No new operation is accepted while DONE is waiting. Nothing is pipelined.
- Classification at accept:
  - Subnormal inputs are flushed to signed zero.
  - Sign = sa ^ sb.
  - Either input is NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0). NV is set only if an input is sNaN (fraction MSB 0).
  - Inf x zero -> canonical qNaN, NV.
  - Inf x finite nonzero, or inf x inf -> signed inf, no flags.
  - Zero x finite -> signed zero, no flags.
  - Special cases go directly to DONE: out_valid is asserted the cycle after accept (latency 1).
- Normal path, with T = accept edge:
  - MUL, T+1..T+SIG_W: shift-add; one multiplier bit per cycle, LSB first, into a 2*SIG_W product register.
  - Exponent: e = ea + eb - BIAS, computed as a signed (EXP_W+2)-bit value.
  - ROUND, T+SIG_W+1:
    - If the product MSB is set, shift right 1 and e+1.
    - Take MAN_W fraction bits, then guard, round and sticky bits (sticky = OR of the remaining bits).
    - Apply rm. A rounding carry out of the significand renormalises and increments e.
  - DONE from T+SIG_W+2: out_valid = 1. Single precision gives 26 cycles, accept to out_valid.
- Overflow (rounded e >= 2^EW-1): OF and NX are set.
  - Result is signed inf for RNE and RMM.
  - RTZ gives max finite.
  - RDN gives +max finite for a positive result and -inf for a negative one.
  - RUP gives +inf for a positive result and -max finite for a negative one.
- Underflow (e <= 0 before rounding): flush to signed zero, UF and NX set. The flush ignores rm.
- NX: any nonzero guard, round or sticky bit on a normal result.
- Width rule: the product register is 2*SIG_W bits and the exponent has 2 extra bits. No intermediate may truncate.

Decomposition:
- Package fpu_pkg holds:
  - rounding-mode localparams RM_RNE..RM_RMM;
  - flag bit indices FLAG_NV..FLAG_NX;
  - state encoding IDLE/MUL/ROUND/DONE;
  - a function that builds the canonical qNaN for a given EXP_W and MAN_W.
- Sub-module fpu_round: a combinational rounder with inputs sign, e, fraction, guard, round, sticky and rm, and outputs the packed value plus OF, UF and NX. It is reused by the future adder.

Test Plan:
- 0x3FC00000 x 0x40000000, rm=RNE -> 0x40400000, flags 0. out_valid exactly 26 cycles after accept; in_ready is 0 throughout.
- 0x3F800001 x 0x3F800001 -> RNE gives 0x3F800002 with NX; RUP gives 0x3F800003 with NX; RTZ gives 0x3F800002 with NX.
- 0x7F7FFFFF x 0x40000000 -> RNE gives 0x7F800000 with OF and NX; RTZ gives 0x7F7FFFFF with OF and NX. 0x00800000 x 0x3F000000 gives 0x00000000 with UF and NX.
- 0x7F800000 x 0x80000000 -> 0x7FC00000 with NV, out_valid 1 cycle after accept. 0x7F800001 x 0x3F800000 -> 0x7FC00000 with NV. 0xFF800000 x 0x40000000 -> 0xFF800000, flags 0.
- Hold out_ready=0 for 10 cycles after out_valid -> result and flags stable and in_valid ignored. Then pulse out_ready -> in_ready returns 1 the next cycle.
- Assert rst at cycle 10 of a MUL -> the next cycle shows in_ready=1 and out_valid=0. A following operation, 0x40000000 x 0x40000000, returns 0x40800000.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, flag bit positions, sequencer states
// and the canonical quiet-NaN builder.
package fpu_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        ROUND,
        DONE
    } state_e;

    // Sign 0, exponent all ones, only the fraction MSB set; callers cast to their width.
    function automatic logic [63:0] canonical_qnan(input int exp_w, input int man_w);
        logic [63:0] v;
        v = ((64'd1 << exp_w) - 64'd1) << man_w;
        v = v | (64'd1 << (man_w - 1));
        return v;
    endfunction

endpackage

// File: rtl/fpu_mult_seq_if.sv
// Operand/result handshake bundle between the FPU register interface and the multiplier.
interface fpu_mult_seq_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   rm;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;

    modport master (
        output in_valid, a, b, rm, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, a, b, rm, out_ready,
        output in_ready, out_valid, result, flags
    );

endinterface

// File: rtl/fpu_round.sv
// Combinational IEEE rounder: takes a normalised significand with guard/round/sticky
// and produces the packed result plus OF/UF/NX, including overflow saturation per mode.
module fpu_round
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                          sign_i,
    input  logic signed [EXP_W+1:0]       e_i,
    input  logic [MAN_W-1:0]              frac_i,
    input  logic                          guard_i,
    input  logic                          round_i,
    input  logic                          sticky_i,
    input  logic [2:0]                    rm_i,
    output logic [EXP_W+MAN_W:0]          result_o,
    output logic                          of_o,
    output logic                          uf_o,
    output logic                          nx_o
);
    localparam int W = 1 + EXP_W + MAN_W;
    localparam logic signed [EXP_W+1:0] E_OVF = (EXP_W+2)'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_INF = '1;
    localparam logic [EXP_W-1:0] EXP_MAX = {{(EXP_W-1){1'b1}}, 1'b0};

    logic                    inexact;
    logic                    rne_inc;
    logic                    inc;
    logic [MAN_W:0]          frac_rnd;
    logic signed [EXP_W+1:0] e_rnd;
    logic [W-1:0]            inf_val;
    logic [W-1:0]            max_val;

    always_comb begin
        inexact = guard_i | round_i | sticky_i;
        rne_inc = guard_i & (round_i | sticky_i | frac_i[0]);
        case (rm_i)
            RM_RNE:  inc = rne_inc;
            RM_RTZ:  inc = 1'b0;
            RM_RDN:  inc = sign_i & inexact;
            RM_RUP:  inc = ~sign_i & inexact;
            RM_RMM:  inc = guard_i;
            default: inc = rne_inc;
        endcase

        // A carry out of the fraction means 1.11..1 rounded up to 10.0: fraction wraps to 0, exponent +1.
        frac_rnd = {1'b0, frac_i} + {{MAN_W{1'b0}}, inc};
        e_rnd    = e_i + {{(EXP_W+1){1'b0}}, frac_rnd[MAN_W]};

        inf_val  = {sign_i, EXP_INF, {MAN_W{1'b0}}};
        max_val  = {sign_i, EXP_MAX, {MAN_W{1'b1}}};

        result_o = {sign_i, e_rnd[EXP_W-1:0], frac_rnd[MAN_W-1:0]};
        of_o     = 1'b0;
        uf_o     = 1'b0;
        nx_o     = inexact;

        if (e_i <= 0) begin
            result_o = {sign_i, {(W-1){1'b0}}};
            uf_o     = 1'b1;
            nx_o     = 1'b1;
        end else if (e_rnd >= E_OVF) begin
            of_o = 1'b1;
            nx_o = 1'b1;
            case (rm_i)
                RM_RTZ:  result_o = max_val;
                RM_RDN:  result_o = sign_i ? inf_val : max_val;
                RM_RUP:  result_o = sign_i ? max_val : inf_val;
                default: result_o = inf_val;
            endcase
        end
    end

endmodule

// File: rtl/fpu_mult_seq.sv
// Iterative IEEE 754 multiplier: one significand bit per cycle via right-shifting
// shift-add, specials resolved at accept, final rounding through fpu_round.
module fpu_mult_seq
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst,
    fpu_mult_seq_if.slave bus
);
    localparam int SIG_W = MAN_W + 1;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int CNT_W = $clog2(SIG_W + 1);
    localparam logic signed [EXP_W+1:0] BIAS = (EXP_W+2)'((1 << (EXP_W - 1)) - 1);
    localparam logic [W-1:0] QNAN = W'(canonical_qnan(EXP_W, MAN_W));

    state_e                  state_q, state_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W+1:0] e_q, e_d;
    logic [SIG_W-1:0]        siga_q, siga_d;
    logic [2*SIG_W-1:0]      prod_q, prod_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2:0]              rm_q, rm_d;
    logic [W-1:0]            result_q, result_d;
    logic [4:0]              flags_q, flags_d;

    logic [EXP_W-1:0]        ea, eb;
    logic [MAN_W-1:0]        fa, fb;
    logic                    a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
    logic                    sign_in;
    logic signed [EXP_W+1:0] e_acc;

    logic [SIG_W:0]          acc_sum;
    logic                    msb;
    logic [2*SIG_W-2:0]      norm;
    logic signed [EXP_W+1:0] e_norm;
    logic [W-1:0]            rnd_result;
    logic                    rnd_of, rnd_uf, rnd_nx;

    // Subnormals count as zero here, so a zero exponent alone decides zero-ness.
    always_comb begin
        ea      = bus.a[W-2:MAN_W];
        eb      = bus.b[W-2:MAN_W];
        fa      = bus.a[MAN_W-1:0];
        fb      = bus.b[MAN_W-1:0];
        sign_in = bus.a[W-1] ^ bus.b[W-1];
        a_zero  = (ea == '0);
        b_zero  = (eb == '0);
        a_inf   = (ea == '1) && (fa == '0);
        b_inf   = (eb == '1) && (fb == '0);
        a_nan   = (ea == '1) && (fa != '0);
        b_nan   = (eb == '1) && (fb != '0);
        a_snan  = a_nan && !fa[MAN_W-1];
        b_snan  = b_nan && !fb[MAN_W-1];
        e_acc   = $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS;
    end

    // Leading one sits at bit 2*SIG_W-1 or 2*SIG_W-2; drop it so norm holds fraction then G/R/S.
    always_comb begin
        msb    = prod_q[2*SIG_W-1];
        norm   = msb ? prod_q[2*SIG_W-2:0] : {prod_q[2*SIG_W-3:0], 1'b0};
        e_norm = e_q + {{(EXP_W+1){1'b0}}, msb};
    end

    fpu_round #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round (
        .sign_i   (sign_q),
        .e_i      (e_norm),
        .frac_i   (norm[2*SIG_W-2:SIG_W]),
        .guard_i  (norm[SIG_W-1]),
        .round_i  (norm[SIG_W-2]),
        .sticky_i (|norm[SIG_W-3:0]),
        .rm_i     (rm_q),
        .result_o (rnd_result),
        .of_o     (rnd_of),
        .uf_o     (rnd_uf),
        .nx_o     (rnd_nx)
    );

    always_comb begin
        state_d  = state_q;
        sign_d   = sign_q;
        e_d      = e_q;
        siga_d   = siga_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        rm_d     = rm_q;
        result_d = result_q;
        flags_d  = flags_q;

        // Multiplier bits live in the low half and are consumed LSB first as the register shifts right.
        acc_sum = {1'b0, prod_q[2*SIG_W-1:SIG_W]} + (prod_q[0] ? {1'b0, siga_q} : '0);

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = sign_in;
                    rm_d    = bus.rm;
                    flags_d = '0;
                    if (a_nan || b_nan) begin
                        result_d         = QNAN;
                        flags_d[FLAG_NV] = a_snan | b_snan;
                        state_d          = DONE;
                    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                        result_d         = QNAN;
                        flags_d[FLAG_NV] = 1'b1;
                        state_d          = DONE;
                    end else if (a_inf || b_inf) begin
                        result_d = {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        state_d  = DONE;
                    end else if (a_zero || b_zero) begin
                        result_d = {sign_in, {(W-1){1'b0}}};
                        state_d  = DONE;
                    end else begin
                        siga_d  = {1'b1, fa};
                        prod_d  = {{SIG_W{1'b0}}, 1'b1, fb};
                        e_d     = e_acc;
                        cnt_d   = '0;
                        state_d = MUL;
                    end
                end
            end
            MUL: begin
                prod_d = {acc_sum, prod_q[SIG_W-1:1]};
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(SIG_W - 1)) begin
                    state_d = ROUND;
                end
            end
            ROUND: begin
                result_d         = rnd_result;
                flags_d          = '0;
                flags_d[FLAG_DZ] = 1'b0;
                flags_d[FLAG_OF] = rnd_of;
                flags_d[FLAG_UF] = rnd_uf;
                flags_d[FLAG_NX] = rnd_nx;
                state_d          = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            e_q      <= '0;
            siga_q   <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            rm_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            sign_q   <= sign_d;
            e_q      <= e_d;
            siga_q   <= siga_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            rm_q     <= rm_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_fpu_mult_seq.sv
// Single-precision bench for fpu_mult_seq: directed corner cases plus randomized
// operands compared against an integer-arithmetic reference of IEEE multiplication.
module tb_fpu_mult_seq;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    fpu_mult_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpu_mult_seq #(
        .EXP_W (8),
        .MAN_W (23)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, want);
        end
    endtask

    // Reference: exact 48-bit integer product, rounded by comparing the discarded remainder to one half.
    function automatic logic [36:0] refMul(input logic [31:0] a, input logic [31:0] b, input logic [2:0] rm);
        int                ea, eb, e, shift;
        longint unsigned   ma, mb, p, keep, rem, half;
        bit                s, aNan, bNan, aSnan, bSnan, aInf, bInf, aZero, bZero, inexact, inc;
        logic [31:0]       infVal, maxVal, res;
        s     = a[31] ^ b[31];
        ea    = int'(a[30:23]);
        eb    = int'(b[30:23]);
        aNan  = (ea == 255) && (a[22:0] != 0);
        bNan  = (eb == 255) && (b[22:0] != 0);
        aSnan = aNan && !a[22];
        bSnan = bNan && !b[22];
        aInf  = (ea == 255) && (a[22:0] == 0);
        bInf  = (eb == 255) && (b[22:0] == 0);
        aZero = (ea == 0);
        bZero = (eb == 0);
        if (aNan || bNan) return {32'h7FC00000, (aSnan || bSnan) ? 5'b10000 : 5'b00000};
        if ((aInf && bZero) || (bInf && aZero)) return {32'h7FC00000, 5'b10000};
        if (aInf || bInf) return {s, 8'hFF, 23'h0, 5'b00000};
        if (aZero || bZero) return {s, 31'h0, 5'b00000};
        ma = {41'd1, a[22:0]};
        mb = {41'd1, b[22:0]};
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            shift = 24;
            e     = e + 1;
        end else begin
            shift = 23;
        end
        if (e <= 0) return {s, 31'h0, 5'b00011};
        keep    = p >> shift;
        rem     = p & ((64'd1 << shift) - 64'd1);
        half    = 64'd1 << (shift - 1);
        inexact = (rem != 0);
        case (rm)
            3'd1:    inc = 1'b0;
            3'd2:    inc = s && inexact;
            3'd3:    inc = !s && inexact;
            3'd4:    inc = (rem >= half);
            default: inc = (rem > half) || ((rem == half) && keep[0]);
        endcase
        keep = keep + 64'(inc);
        if (keep == (64'd1 << 24)) begin
            keep = 64'd1 << 23;
            e    = e + 1;
        end
        if (e >= 255) begin
            infVal = {s, 8'hFF, 23'h0};
            maxVal = {s, 8'hFE, 23'h7FFFFF};
            case (rm)
                3'd1:    res = maxVal;
                3'd2:    res = s ? infVal : maxVal;
                3'd3:    res = s ? maxVal : infVal;
                default: res = infVal;
            endcase
            return {res, 5'b00101};
        end
        res = {s, e[7:0], keep[22:0]};
        return {res, 4'b0000, inexact};
    endfunction

    function automatic int refLatency(input logic [31:0] a, input logic [31:0] b);
        if (a[30:23] == 8'h00 || a[30:23] == 8'hFF || b[30:23] == 8'h00 || b[30:23] == 8'hFF)
            return 1;
        return 26;
    endfunction

    function automatic logic [31:0] randOperand();
        logic [31:0] v;
        int          mode;
        v    = $urandom;
        mode = $urandom_range(0, 9);
        if (mode < 6) begin
            v[30:23] = 8'($urandom_range(100, 154));
        end else if (mode < 8) begin
            v[30:23] = 8'($urandom_range(1, 254));
        end else if (mode == 8) begin
            v[30:23] = 8'($urandom_range(120, 134));
            v[22:0]  = 23'h7FFFFF ^ 23'($urandom_range(0, 3));
        end
        return v;
    endfunction

    // Latency counts cycles from the accept cycle to the first cycle with out_valid high.
    task automatic applyStimulus(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] trm,
                                 output int lat, output bit readySeen);
        @(negedge clk);
        bus.a        = ta;
        bus.b        = tb;
        bus.rm       = trm;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat          = 1;
        readySeen    = 1'b0;
        while (!bus.out_valid && lat < 200) begin
            readySeen = readySeen | bus.in_ready;
            @(negedge clk);
            lat++;
        end
        readySeen = readySeen | bus.in_ready;
        checkOutput("out_valid_timeout", 64'(bus.out_valid), 64'd1);
    endtask

    task automatic releaseOutput();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkOutput("in_ready_after_pop", 64'(bus.in_ready), 64'd1);
        checkOutput("out_valid_after_pop", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic runOp(input string tag, input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] trm);
        logic [36:0] want;
        int          lat;
        bit          readySeen;
        want = refMul(ta, tb, trm);
        applyStimulus(ta, tb, trm, lat, readySeen);
        checkOutput({tag, "_result"}, 64'(bus.result), 64'(want[36:5]));
        checkOutput({tag, "_flags"}, 64'(bus.flags), 64'(want[4:0]));
        checkOutput({tag, "_latency"}, 64'(lat), 64'(refLatency(ta, tb)));
        checkOutput({tag, "_in_ready_busy"}, 64'(readySeen), 64'd0);
        releaseOutput();
    endtask

    initial begin
        logic [36:0] want;
        int          lat;
        bit          readySeen;
        bit          validSeen;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.rm        = '0;
        bus.out_ready = 1'b0;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_result", 64'(bus.result), 64'd0);
        checkOutput("reset_flags", 64'(bus.flags), 64'd0);
        rst = 1'b0;

        runOp("basic_1p5x2", 32'h3FC00000, 32'h40000000, 3'd0);
        checkOutput("basic_value", 64'(bus.result), 64'h40400000);
        runOp("lsb_rne", 32'h3F800001, 32'h3F800001, 3'd0);
        runOp("lsb_rup", 32'h3F800001, 32'h3F800001, 3'd3);
        runOp("lsb_rtz", 32'h3F800001, 32'h3F800001, 3'd1);
        runOp("ovf_rne", 32'h7F7FFFFF, 32'h40000000, 3'd0);
        runOp("ovf_rtz", 32'h7F7FFFFF, 32'h40000000, 3'd1);
        runOp("ovf_rdn_neg", 32'hFF7FFFFF, 32'h40000000, 3'd2);
        runOp("ovf_rup_neg", 32'hFF7FFFFF, 32'h40000000, 3'd3);
        runOp("ovf_rmm", 32'h7F7FFFFF, 32'h40000000, 3'd4);
        runOp("unf_flush", 32'h00800000, 32'h3F000000, 3'd3);
        runOp("inf_x_zero", 32'h7F800000, 32'h80000000, 3'd0);
        runOp("snan", 32'h7F800001, 32'h3F800000, 3'd0);
        runOp("qnan", 32'h3F800000, 32'hFFC12345, 3'd0);
        runOp("neg_inf", 32'hFF800000, 32'h40000000, 3'd0);
        runOp("subnormal_zero", 32'h00000001, 32'hC0000000, 3'd0);
        runOp("rm_reserved", 32'h3F800001, 32'h3F800001, 3'd6);

        // Output held back: result/flags must stay put and a new request must be ignored.
        want = refMul(32'h3FC00000, 32'h40000000, 3'd0);
        applyStimulus(32'h3FC00000, 32'h40000000, 3'd0, lat, readySeen);
        bus.a        = 32'h40000000;
        bus.b        = 32'h40000000;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("hold_result", 64'(bus.result), 64'(want[36:5]));
            checkOutput("hold_flags", 64'(bus.flags), 64'(want[4:0]));
            checkOutput("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.in_valid = 1'b0;
        releaseOutput();

        // Reset in the middle of a multiply abandons it.
        @(negedge clk);
        bus.a        = 32'h3FC00000;
        bus.b        = 32'h40000000;
        bus.rm       = 3'd0;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        checkOutput("mid_mul_busy", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("abort_out_valid", 64'(bus.out_valid), 64'd0);
        validSeen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            validSeen = validSeen | bus.out_valid;
        end
        checkOutput("abort_no_output", 64'(validSeen), 64'd0);
        runOp("after_reset", 32'h40000000, 32'h40000000, 3'd0);
        checkOutput("after_reset_value", 64'(bus.result), 64'h40800000);

        for (int i = 0; i < 200; i++) begin
            runOp("rand", randOperand(), randOperand(), 3'($urandom_range(0, 7)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
